// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller:
// state encoding, a width-aware saturating add and a packed price lookup.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        RETURN
    } vend_state_e;

    localparam int MAX_VEC_W = 512;

    // Saturates at 2^w-1; operands are zero-extended by the caller.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] maxVal;
        sum = {1'b0, a} + {1'b0, b};
        maxVal = (33'd1 << w) - 33'd1;
        return (sum > maxVal) ? 32'(maxVal) : 32'(sum);
    endfunction

    function automatic logic [31:0] price_of(input logic [MAX_VEC_W-1:0] vec, input int idx, input int w);
        logic [MAX_VEC_W-1:0] mask;
        mask = (MAX_VEC_W'(1) << w) - MAX_VEC_W'(1);
        return 32'((vec >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Front-end/actuator bundle of the vending controller; slave = controller side.
// Audit outputs exist only when VEND_AUDIT_EN is defined.
interface vend_ctrl_multi_if #(
    parameter int NUM_PRODUCTS = 4,
    parameter int MONEY_W      = 8,
    parameter int COIN_W       = 4,
    parameter int STOCK_W      = 4
);
    localparam int SEL_W = $clog2(NUM_PRODUCTS);

    logic                    coin_valid;
    logic [COIN_W-1:0]       coin_value;
    logic                    sel_valid;
    logic [SEL_W-1:0]        sel;
    logic                    cancel;
    logic                    restock_valid;
    logic [SEL_W-1:0]        restock_id;
    logic [STOCK_W-1:0]      restock_qty;
    logic [MONEY_W-1:0]      credit;
    logic                    dispense_valid;
    logic [SEL_W-1:0]        dispense_id;
    logic                    change_valid;
    logic [MONEY_W-1:0]      change_amt;
    logic [NUM_PRODUCTS-1:0] sold_out;
    logic                    busy;
    logic                    err_pulse;
`ifdef VEND_AUDIT_EN
    logic [15:0]             sales_count;
    logic [23:0]             revenue;
`endif

    modport master (
        output coin_valid, coin_value, sel_valid, sel, cancel,
               restock_valid, restock_id, restock_qty,
`ifdef VEND_AUDIT_EN
        input  sales_count, revenue,
`endif
        input  credit, dispense_valid, dispense_id, change_valid,
               change_amt, sold_out, busy, err_pulse
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, sel, cancel,
               restock_valid, restock_id, restock_qty,
`ifdef VEND_AUDIT_EN
        output sales_count, revenue,
`endif
        output credit, dispense_valid, dispense_id, change_valid,
               change_amt, sold_out, busy, err_pulse
    );

endinterface

// File: rtl/vend_stock_bank.sv
// Per-product stock counters: merges a restock and a vend decrement landing
// on the same product in one cycle, and flags empty products.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 5
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            i_dec_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0] i_dec_id,
    input  logic                            i_add_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0] i_add_id,
    input  logic [STOCK_W-1:0]              i_add_qty,
    output logic [NUM_PRODUCTS-1:0]         o_sold_out
);

    logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];
    logic [STOCK_W-1:0] w_base  [NUM_PRODUCTS];
    logic [STOCK_W-1:0] w_add   [NUM_PRODUCTS];
    logic [STOCK_W-1:0] w_next  [NUM_PRODUCTS];

    // Decrement first (stock is non-zero whenever a vend is in flight) so the
    // clamp applies to stock+qty-1 rather than to stock+qty.
    always_comb begin
        o_sold_out = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            w_base[i]     = r_stock[i] - ((i_dec_valid && int'(i_dec_id) == i) ? STOCK_W'(1) : STOCK_W'(0));
            w_add[i]      = (i_add_valid && int'(i_add_id) == i) ? i_add_qty : '0;
            w_next[i]     = STOCK_W'(sat_add(32'(w_base[i]), 32'(w_add[i]), STOCK_W));
            o_sold_out[i] = (r_stock[i] == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= w_next[i];
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, vend, change/refund.
// Define VEND_AUDIT_EN to add the sales_count/revenue audit outputs.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                            NUM_PRODUCTS = 4,
    parameter int                            MONEY_W      = 8,
    parameter int                            COIN_W       = 4,
    parameter int                            STOCK_W      = 4,
    parameter logic [NUM_PRODUCTS*MONEY_W-1:0] PRICE_VEC  = {8'd4, 8'd6, 8'd5, 8'd5},
    parameter int                            INIT_STOCK   = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    vend_ctrl_multi_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_PRODUCTS);

    vend_state_e         r_state, w_state;
    logic [MONEY_W-1:0]  r_credit, w_credit;
    logic [MONEY_W-1:0]  r_price, w_price;
    logic [SEL_W-1:0]    r_sel, w_sel;
    logic                r_dispense_valid, w_dispense_valid;
    logic [SEL_W-1:0]    r_dispense_id, w_dispense_id;
    logic                r_change_valid, w_change_valid;
    logic [MONEY_W-1:0]  r_change_amt, w_change_amt;
    logic                r_busy, w_busy;
    logic                r_err, w_err;
    logic                w_dec_valid;
    logic [NUM_PRODUCTS-1:0] w_sold_out;
    logic [MONEY_W-1:0]  w_sel_price;
    logic                w_sel_ok;

    assign w_sel_price = MONEY_W'(price_of(MAX_VEC_W'(PRICE_VEC), int'(bus.sel), MONEY_W));
    assign w_sel_ok    = (int'(bus.sel) < NUM_PRODUCTS) && (r_credit >= w_sel_price) && !w_sold_out[bus.sel];

    // Outputs are computed one state ahead so that dispense/change pulses are
    // registered and line up with the VEND and RETURN cycles respectively.
    always_comb begin
        w_state          = r_state;
        w_credit         = r_credit;
        w_price          = r_price;
        w_sel            = r_sel;
        w_dispense_valid = 1'b0;
        w_dispense_id    = r_dispense_id;
        w_change_valid   = 1'b0;
        w_change_amt     = '0;
        w_busy           = 1'b0;
        w_err            = 1'b0;
        w_dec_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.coin_valid) begin
                    w_credit = MONEY_W'(bus.coin_value);
                    w_state  = CREDIT;
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    w_change_valid = (r_credit != '0);
                    w_change_amt   = r_credit;
                    w_busy         = 1'b1;
                    w_state        = RETURN;
                end else if (bus.coin_valid) begin
                    w_credit = MONEY_W'(sat_add(32'(r_credit), 32'(bus.coin_value), MONEY_W));
                end else if (bus.sel_valid) begin
                    if (w_sel_ok) begin
                        w_sel            = bus.sel;
                        w_price          = w_sel_price;
                        w_dispense_valid = 1'b1;
                        w_dispense_id    = bus.sel;
                        w_busy           = 1'b1;
                        w_state          = VEND;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            VEND: begin
                w_dec_valid    = 1'b1;
                w_credit       = r_credit - r_price;
                w_change_valid = (w_credit != '0);
                w_change_amt   = w_credit;
                w_busy         = 1'b1;
                w_state        = RETURN;
            end
            RETURN: begin
                w_credit = '0;
                w_state  = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_credit         <= '0;
            r_price          <= '0;
            r_sel            <= '0;
            r_dispense_valid <= 1'b0;
            r_dispense_id    <= '0;
            r_change_valid   <= 1'b0;
            r_change_amt     <= '0;
            r_busy           <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_credit         <= w_credit;
            r_price          <= w_price;
            r_sel            <= w_sel;
            r_dispense_valid <= w_dispense_valid;
            r_dispense_id    <= w_dispense_id;
            r_change_valid   <= w_change_valid;
            r_change_amt     <= w_change_amt;
            r_busy           <= w_busy;
            r_err            <= w_err;
        end
    end

    vend_stock_bank #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .STOCK_W      (STOCK_W),
        .INIT_STOCK   (INIT_STOCK)
    ) u_stock (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_dec_valid  (w_dec_valid),
        .i_dec_id     (r_sel),
        .i_add_valid  (bus.restock_valid),
        .i_add_id     (bus.restock_id),
        .i_add_qty    (bus.restock_qty),
        .o_sold_out   (w_sold_out)
    );

`ifdef VEND_AUDIT_EN
    logic [15:0] r_sales_count;
    logic [23:0] r_revenue;

    // Counted on the cycle dispense_valid is high, using the latched price.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sales_count <= '0;
            r_revenue     <= '0;
        end else if (r_state == VEND) begin
            r_sales_count <= r_sales_count + 16'd1;
            r_revenue     <= 24'(sat_add(32'(r_revenue), 32'(r_price), 24));
        end
    end

    assign bus.sales_count = r_sales_count;
    assign bus.revenue     = r_revenue;
`endif

    assign bus.credit         = r_credit;
    assign bus.dispense_valid = r_dispense_valid;
    assign bus.dispense_id    = r_dispense_id;
    assign bus.change_valid   = r_change_valid;
    assign bus.change_amt     = r_change_amt;
    assign bus.sold_out       = w_sold_out;
    assign bus.busy           = r_busy;
    assign bus.err_pulse      = r_err;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: a vector table for single-cycle behaviour
// plus hand-written sequences for stock, saturation and reset corner cases.
module tb_vend_ctrl_multi;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    vend_ctrl_multi_if #(
        .NUM_PRODUCTS (4),
        .MONEY_W      (8),
        .COIN_W       (4),
        .STOCK_W      (4)
    ) vif ();

    // Prices chosen so product 0..3 cost 4,6,5,5.
    vend_ctrl_multi #(
        .NUM_PRODUCTS (4),
        .MONEY_W      (8),
        .COIN_W       (4),
        .STOCK_W      (4),
        .PRICE_VEC    ({8'd5, 8'd5, 8'd6, 8'd4}),
        .INIT_STOCK   (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (vif)
    );

    typedef struct {
        logic       cv;
        logic [3:0] cval;
        logic       sv;
        logic [1:0] sel;
        logic       can;
        logic [7:0] credit;
        logic       dv;
        logic [1:0] did;
        logic       chv;
        logic [7:0] cha;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs [18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic cv, input logic [3:0] cval, input logic sv,
                                 input logic [1:0] sel, input logic can, input logic rv,
                                 input logic [1:0] rid, input logic [3:0] rqty);
        vif.coin_valid    = cv;
        vif.coin_value    = cval;
        vif.sel_valid     = sv;
        vif.sel           = sel;
        vif.cancel        = can;
        vif.restock_valid = rv;
        vif.restock_id    = rid;
        vif.restock_qty   = rqty;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    endtask

    // Full purchase: coin, select, (optional restock during VEND), return.
    task automatic vendOnce(input logic [1:0] id, input logic [3:0] coinVal, input logic [7:0] expChange,
                            input logic doRestock, input logic [3:0] qty);
        applyStimulus(1'b1, coinVal, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, id, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("vend.dispense_valid", 32'(vif.dispense_valid), 32'd1);
        checkOutput("vend.dispense_id", 32'(vif.dispense_id), 32'(id));
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, doRestock, id, qty);
        checkOutput("vend.change_valid", 32'(vif.change_valid), 32'(expChange != 8'd0));
        checkOutput("vend.change_amt", 32'(vif.change_amt), 32'(expChange));
        idleCycle();
        checkOutput("vend.busy_after", 32'(vif.busy), 32'd0);
    endtask

    initial begin
        //            cv    cval  sv    sel   can   credit dv    did   chv   cha    busy  err
        vecs[0]  = '{1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 8'd2, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 8'd4, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd3, 1'b0, 2'd0, 1'b0, 8'd7, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 8'd7, 1'b1, 2'd1, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd1, 1'b0, 2'd0, 1'b1, 8'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'd3, 1'b0, 2'd0, 1'b0, 8'd3, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 1'b1, 2'd2, 1'b0, 8'd3, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd3, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 8'd3, 1'b0, 2'd0, 1'b1, 8'd3, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 8'd5, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'd1, 1'b1, 2'd0, 1'b0, 8'd6, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 8'd6, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd2, 1'b0, 2'd0, 1'b1, 8'd2, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0};

        reset_n = 1'b0;
        vif.coin_valid    = 1'b0;
        vif.coin_value    = 4'd0;
        vif.sel_valid     = 1'b0;
        vif.sel           = 2'd0;
        vif.cancel        = 1'b0;
        vif.restock_valid = 1'b0;
        vif.restock_id    = 2'd0;
        vif.restock_qty   = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.credit", 32'(vif.credit), 32'd0);
        checkOutput("reset.dispense_valid", 32'(vif.dispense_valid), 32'd0);
        checkOutput("reset.dispense_id", 32'(vif.dispense_id), 32'd0);
        checkOutput("reset.change_valid", 32'(vif.change_valid), 32'd0);
        checkOutput("reset.change_amt", 32'(vif.change_amt), 32'd0);
        checkOutput("reset.busy", 32'(vif.busy), 32'd0);
        checkOutput("reset.err_pulse", 32'(vif.err_pulse), 32'd0);
        checkOutput("reset.sold_out", 32'(vif.sold_out), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sel, vecs[i].can, 1'b0, 2'd0, 4'd0);
            checkOutput($sformatf("vec%0d.credit", i), 32'(vif.credit), 32'(vecs[i].credit));
            checkOutput($sformatf("vec%0d.dispense_valid", i), 32'(vif.dispense_valid), 32'(vecs[i].dv));
            if (vecs[i].dv)
                checkOutput($sformatf("vec%0d.dispense_id", i), 32'(vif.dispense_id), 32'(vecs[i].did));
            checkOutput($sformatf("vec%0d.change_valid", i), 32'(vif.change_valid), 32'(vecs[i].chv));
            checkOutput($sformatf("vec%0d.change_amt", i), 32'(vif.change_amt), 32'(vecs[i].cha));
            checkOutput($sformatf("vec%0d.busy", i), 32'(vif.busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d.err_pulse", i), 32'(vif.err_pulse), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d.sold_out", i), 32'(vif.sold_out), 32'd0);
        end

        // Product 0 was sold once in the table; four more empties it.
        for (int k = 0; k < 4; k++) begin
            vendOnce(2'd0, 4'd4, 8'd0, 1'b0, 4'd0);
            if (k == 2) checkOutput("p0.one_left", 32'(vif.sold_out), 32'd0);
        end
        checkOutput("p0.sold_out", 32'(vif.sold_out), 32'b0001);

        applyStimulus(1'b1, 4'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("p0.sixth.err_pulse", 32'(vif.err_pulse), 32'd1);
        checkOutput("p0.sixth.dispense_valid", 32'(vif.dispense_valid), 32'd0);
        checkOutput("p0.sixth.credit", 32'(vif.credit), 32'd9);
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        checkOutput("p0.refund.change_valid", 32'(vif.change_valid), 32'd1);
        checkOutput("p0.refund.change_amt", 32'(vif.change_amt), 32'd9);
        idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd2);
        checkOutput("p0.restocked", 32'(vif.sold_out), 32'd0);

        // Product 3: 5 -> 4, then vend with restock 15 in the same cycle -> 15.
        vendOnce(2'd3, 4'd5, 8'd0, 1'b0, 4'd0);
        vendOnce(2'd3, 4'd5, 8'd0, 1'b1, 4'd15);
        for (int k = 0; k < 15; k++) begin
            vendOnce(2'd3, 4'd5, 8'd0, 1'b0, 4'd0);
            if (k == 13) checkOutput("p3.after14", 32'(vif.sold_out), 32'd0);
        end
        checkOutput("p3.after15", 32'(vif.sold_out), 32'b1000);

        // Credit saturation at 255.
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 4'd15, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("sat.credit240", 32'(vif.credit), 32'd240);
        applyStimulus(1'b1, 4'd14, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("sat.credit254", 32'(vif.credit), 32'd254);
        applyStimulus(1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("sat.credit255", 32'(vif.credit), 32'd255);
        applyStimulus(1'b1, 4'd15, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("sat.credit_hold", 32'(vif.credit), 32'd255);
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0);
        checkOutput("sat.refund_amt", 32'(vif.change_amt), 32'd255);
        idleCycle();

        // Reset asserted while in VEND.
        applyStimulus(1'b1, 4'd4, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("rstvend.in_vend", 32'(vif.dispense_valid), 32'd1);
        vif.sel_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstvend.dispense_valid", 32'(vif.dispense_valid), 32'd0);
        checkOutput("rstvend.credit", 32'(vif.credit), 32'd0);
        checkOutput("rstvend.sold_out", 32'(vif.sold_out), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rstvend.change_valid", 32'(vif.change_valid), 32'd0);
        reset_n = 1'b1;
        idleCycle();
        checkOutput("rstvend.after.change_valid", 32'(vif.change_valid), 32'd0);
        checkOutput("rstvend.after.dispense_valid", 32'(vif.dispense_valid), 32'd0);
        checkOutput("rstvend.after.busy", 32'(vif.busy), 32'd0);
        checkOutput("rstvend.after.credit", 32'(vif.credit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
